// File: rtl/serial_word_deserializer.sv
// rtl/serial_word_deserializer.sv - serial-to-parallel word receiver with valid/ready output and sticky overrun
module serial_word_deserializer #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       serial_in,
  input  logic                       shift_en,
  input  logic                       sync,
  output logic [WIDTH-1:0]           data_out,
  output logic                       data_valid,
  input  logic                       data_ready,
  output logic                       overrun,
  input  logic                       overrun_clr,
  output logic [$clog2(WIDTH+1)-1:0] bit_count
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RECV = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    bit_count_q, bit_count_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] shifted;
  logic             complete;
  logic             drop;

  always_comb begin
    if (LSB_FIRST) shifted = {serial_in, sreg_q[WIDTH-1:1]};
    else           shifted = {sreg_q[WIDTH-2:0], serial_in};
  end

  // Bit counting and word framing; sync restarts the frame, keeping the current bit if strobed.
  always_comb begin
    state_d     = state_q;
    bit_count_d = bit_count_q;
    sreg_d      = sreg_q;
    complete    = 1'b0;
    if (shift_en) begin
      sreg_d = shifted;
      if (sync || state_q == IDLE) begin
        bit_count_d = CW'(1);
        state_d     = RECV;
      end else if (bit_count_q == CW'(WIDTH-1)) begin
        complete    = 1'b1;
        bit_count_d = '0;
        state_d     = IDLE;
      end else begin
        bit_count_d = bit_count_q + CW'(1);
      end
    end else if (sync) begin
      bit_count_d = '0;
      state_d     = IDLE;
    end
  end

  // A completed word may replace the held one only if the slot is empty or being consumed this edge.
  always_comb begin
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    drop         = 1'b0;
    if (complete && (!data_valid_q || data_ready)) begin
      data_out_d   = shifted;
      data_valid_d = 1'b1;
    end else begin
      if (complete) drop = 1'b1;
      if (data_valid_q && data_ready) data_valid_d = 1'b0;
    end
    overrun_d = (overrun_q & ~overrun_clr) | drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_count_q  <= '0;
      sreg_q       <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_count_q  <= bit_count_d;
      sreg_q       <= sreg_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign overrun    = overrun_q;
  assign bit_count  = bit_count_q;

endmodule
